multicycle_alu: RTL and testbench

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/alu_pkg.sv | 23 ++
 rtl/multicycle_alu_if.sv | 14 +
 rtl/alu_muldiv_seq.sv | 54 +++++
 rtl/multicycle_alu.sv | 140 ++++++++++++++
 tb/tb_multicycle_alu.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state type and default datapath width for multicycle_alu.
package alu_pkg;
  localparam int ALU_N = 32;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_PASS  = 4'd10;
  localparam logic [3:0] OP_MUL   = 4'd11;
  localparam logic [3:0] OP_MULHU = 4'd12;
  localparam logic [3:0] OP_DIVU  = 4'd13;
  localparam logic [3:0] OP_REMU  = 4'd14;
  localparam logic [3:0] OP_RES   = 4'd15;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} alu_state_e;
endpackage

// File: rtl/multicycle_alu_if.sv
// Request/response bundle of multicycle_alu; master drives operands, slave is the ALU.
interface multicycle_alu_if #(parameter int N = alu_pkg::ALU_N);
  logic         start;
  logic [3:0]   alu_control;
  logic [N-1:0] a, b;
  logic         busy, done;
  logic [N-1:0] alu_out;
  logic         z, v, c, s;

  modport master (output start, alu_control, a, b,
                  input  busy, done, alu_out, z, v, c, s);
  modport slave  (input  start, alu_control, a, b,
                  output busy, done, alu_out, z, v, c, s);
endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative radix-2 shift-add multiplier / restoring divider sharing one 2N-bit accumulator.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int N = ALU_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic           is_div,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] acc_nxt,
  output logic           last
);
  localparam int CW = $clog2(N + 1);

  logic [2*N-1:0] acc;
  logic [N-1:0]   opnd;
  logic [CW-1:0]  cnt;
  logic           div_q;
  logic [N:0]     sum, diff;

  // Mul: hi += opnd when lsb set, then shift right; result lands as {hi, lo}.
  // Div: shift {rem, quo} left, subtract divisor from rem, quotient bits enter at lsb.
  always_comb begin
    sum  = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, opnd} : {(N+1){1'b0}});
    diff = acc[2*N-1:N-1] - {1'b0, opnd};
    if (div_q)
      acc_nxt = diff[N] ? {acc[2*N-2:0], 1'b0} : {diff[N-1:0], acc[N-2:0], 1'b1};
    else
      acc_nxt = {sum, acc[N-1:1]};
  end

  assign last = (cnt == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      opnd  <= '0;
      cnt   <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      acc   <= {{N{1'b0}}, (is_div ? a : b)};
      opnd  <= is_div ? b : a;
      cnt   <= CW'(N);
      div_q <= is_div;
    end else if (step && cnt != '0) begin
      acc <= acc_nxt;
      cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith, bit-serial shifts, optional iterative mul/div.
// Define ALU_MULDIV_EN to build the multiply/divide datapath (opcodes 11-14).
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int N   = ALU_N,
  parameter int SHW = $clog2(N)
) (
  input  logic clk,
  input  logic rst,
  multicycle_alu_if.slave bus
);
  alu_state_e     state, state_nxt;
  logic [3:0]     op_q;
  logic [N-1:0]   sh_q, shift_nxt, res_sc, run_res, b_eff, out_q;
  logic [SHW-1:0] cnt_q, shamt;
  logic [N:0]     sum;
  logic           c_sc, v_sc, is_shift, md_multi, multi, accept, run_last;
  logic           z_q, v_q, c_q, s_q;

  assign shamt    = bus.b[SHW-1:0];
  assign accept   = (state == IDLE) && bus.start;
  assign is_shift = bus.alu_control inside {OP_SLL, OP_SRL, OP_SRA};
  assign multi    = (is_shift && shamt != '0) || md_multi;

`ifdef ALU_MULDIV_EN
  logic [2*N-1:0] md_acc;
  logic           md_last, is_div;

  assign is_div   = bus.alu_control inside {OP_DIVU, OP_REMU};
  // Divide by zero short-circuits to the single-cycle path.
  assign md_multi = (bus.alu_control inside {OP_MUL, OP_MULHU}) || (is_div && bus.b != '0);

  alu_muldiv_seq #(.N(N)) u_muldiv (
    .clk(clk), .rst(rst), .load(accept), .step(state == RUN), .is_div(is_div),
    .a(bus.a), .b(bus.b), .acc_nxt(md_acc), .last(md_last)
  );
`else
  assign md_multi = 1'b0;
`endif

  always_comb begin
    b_eff  = (bus.alu_control == OP_SUB) ? ~bus.b : bus.b;
    sum    = {1'b0, bus.a} + {1'b0, b_eff} + {{N{1'b0}}, bus.alu_control == OP_SUB};
    res_sc = '0;
    c_sc   = 1'b0;
    v_sc   = 1'b0;
    case (bus.alu_control)
      OP_ADD, OP_SUB: begin
        res_sc = sum[N-1:0];
        c_sc   = sum[N];
        v_sc   = (bus.a[N-1] == b_eff[N-1]) && (sum[N-1] != bus.a[N-1]);
      end
      OP_AND:                  res_sc = bus.a & bus.b;
      OP_OR:                   res_sc = bus.a | bus.b;
      OP_XOR:                  res_sc = bus.a ^ bus.b;
      OP_SLL, OP_SRL, OP_SRA:  res_sc = bus.a;  // only reached with shamt == 0
      OP_SLT:                  res_sc = {{(N-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      OP_SLTU:                 res_sc = {{(N-1){1'b0}}, bus.a < bus.b};
      OP_PASS:                 res_sc = bus.a;
`ifdef ALU_MULDIV_EN
      OP_DIVU:                 res_sc = '1;
      OP_REMU:                 res_sc = bus.a;
`endif
      default:                 res_sc = '0;
    endcase
  end

  always_comb begin
    case (op_q)
      OP_SLL:  shift_nxt = sh_q << 1;
      OP_SRL:  shift_nxt = sh_q >> 1;
      default: shift_nxt = {sh_q[N-1], sh_q[N-1:1]};
    endcase
    run_res  = shift_nxt;
    run_last = (cnt_q == SHW'(1));
`ifdef ALU_MULDIV_EN
    if (!(op_q inside {OP_SLL, OP_SRL, OP_SRA})) begin
      run_last = md_last;
      run_res  = (op_q inside {OP_MULHU, OP_REMU}) ? md_acc[2*N-1:N] : md_acc[N-1:0];
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = multi ? RUN : FINISH;
      RUN:     if (run_last)  state_nxt = FINISH;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= '0;
      sh_q  <= '0;
      cnt_q <= '0;
      out_q <= '0;
      z_q   <= 1'b1;
      v_q   <= 1'b0;
      c_q   <= 1'b0;
      s_q   <= 1'b0;
    end else if (accept) begin
      op_q  <= bus.alu_control;
      sh_q  <= bus.a;
      cnt_q <= shamt;
      if (!multi) begin
        out_q <= res_sc;
        z_q   <= (res_sc == '0);
        s_q   <= res_sc[N-1];
        c_q   <= c_sc;
        v_q   <= v_sc;
      end
    end else if (state == RUN) begin
      sh_q  <= shift_nxt;
      cnt_q <= cnt_q - SHW'(1);
      if (run_last) begin
        out_q <= run_res;
        z_q   <= (run_res == '0);
        s_q   <= run_res[N-1];
        c_q   <= 1'b0;
        v_q   <= 1'b0;
      end
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == FINISH);
  assign bus.alu_out = out_q;
  assign bus.z       = z_q;
  assign bus.v       = v_q;
  assign bus.c       = c_q;
  assign bus.s       = s_q;
endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: driver queues expected results, monitor checks each done.
module tb_multicycle_alu;
  import alu_pkg::*;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_alu_if #(.N(N)) bus();
  multicycle_alu #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    string        name;
    logic [N-1:0] out;
    logic         z, v, c, s;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no done (out=%0h)", bus.alu_out);
      end else begin
        e = sb.pop_front();
        chk({e.name, ".out"}, bus.alu_out, e.out);
        chk({e.name, ".zvcs"}, {bus.z, bus.v, bus.c, bus.s}, {e.z, e.v, e.c, e.s});
        chk({e.name, ".lat"}, cyc - e.acc + 1, e.lat);
      end
    end
  end

  task automatic push(input string name, input logic [N-1:0] out,
                      input logic z, v, c, s, input int lat);
    exp_t e;
    e.name = name; e.out = out; e.z = z; e.v = v; e.c = c; e.s = s; e.lat = lat;
    e.acc  = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [3:0] op, input logic [N-1:0] a, b);
    bus.start = 1'b1; bus.alu_control = op; bus.a = a; bus.b = b;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s.timeout: got no done expected done within 200 cycles", name);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [N-1:0] a, b,
                        input logic [N-1:0] out, input logic z, v, c, s, input int lat);
    push(name, out, z, v, c, s, lat);
    drive(op, a, b);
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.alu_control = '0; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    chk("reset.out", bus.alu_out, 0);
    chk("reset.zvcs", {bus.z, bus.v, bus.c, bus.s}, 4'b1000);
    chk("reset.busy_done", {bus.busy, bus.done}, 2'b00);
    rst = 1'b0;
    @(negedge clk);

    run_op("add_ovf",  OP_ADD,  32'h7FFFFFFF, 32'h1,        32'h80000000, 0, 1, 0, 1, 1);
    run_op("add_cry",  OP_ADD,  32'hFFFFFFFF, 32'h1,        32'h0,        1, 0, 1, 0, 1);
    run_op("sub_neg",  OP_SUB,  32'h0,        32'h1,        32'hFFFFFFFF, 0, 0, 0, 1, 1);
    run_op("sub_ovf",  OP_SUB,  32'h80000000, 32'h1,        32'h7FFFFFFF, 0, 1, 1, 0, 1);
    run_op("and",      OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0, 1, 1);
    run_op("or",       OP_OR,   32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 0, 0, 0, 0, 1);
    run_op("xor",      OP_XOR,  32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 0, 0, 0, 0, 1);
    run_op("slt",      OP_SLT,  32'hFFFFFFFF, 32'h1,        32'h1,        0, 0, 0, 0, 1);
    run_op("sltu_f",   OP_SLTU, 32'hFFFFFFFF, 32'h1,        32'h0,        1, 0, 0, 0, 1);
    run_op("sltu_t",   OP_SLTU, 32'h1,        32'hFFFFFFFF, 32'h1,        0, 0, 0, 0, 1);
    run_op("reserved", OP_RES,  32'h5,        32'h5,        32'h0,        1, 0, 0, 0, 1);
    run_op("sll0",     OP_SLL,  32'h3,        32'h0,        32'h3,        0, 0, 0, 0, 1);
    run_op("sll_lo",   OP_SLL,  32'h3,        32'h21,       32'h6,        0, 0, 0, 0, 2);
    run_op("sll31",    OP_SLL,  32'h1,        32'h1F,       32'h80000000, 0, 0, 0, 1, 32);
    run_op("srl4",     OP_SRL,  32'h80000000, 32'h4,        32'h08000000, 0, 0, 0, 0, 5);

    // SRA with start pulses while busy: no extra done may appear.
    push("sra4", 32'hF8000000, 0, 0, 0, 1, 5);
    drive(OP_SRA, 32'h80000000, 32'h4);
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); chk("sra4.busy", bus.busy, 1); drive(OP_ADD, 32'h1, 32'h1);
    @(negedge clk); bus.start = 1'b0;
    wait_idle("sra4");

    // Start presented during FINISH must be dropped.
    push("srl1", 32'h78, 0, 0, 0, 0, 2);
    drive(OP_SRL, 32'hF0, 32'h1);
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); chk("srl1.finish_done", bus.done, 1); drive(OP_ADD, 32'h2, 32'h2);
    @(negedge clk); bus.start = 1'b0;
    wait_idle("srl1");
    chk("srl1.held", bus.alu_out, 32'h78);

`ifdef ALU_MULDIV_EN
    run_op("mulhu",  OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0, 0, 1, 33);
    run_op("mul",    OP_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        0, 0, 0, 0, 33);
    run_op("divu",   OP_DIVU,  32'd100,      32'd7,        32'd14,       0, 0, 0, 0, 33);
    run_op("remu",   OP_REMU,  32'd100,      32'd7,        32'd2,        0, 0, 0, 0, 33);
    run_op("divu0",  OP_DIVU,  32'd100,      32'd0,        32'hFFFFFFFF, 0, 0, 0, 1, 1);
    run_op("remu0",  OP_REMU,  32'd9,        32'd0,        32'd9,        0, 0, 0, 0, 1);
`else
    run_op("mul_off",   OP_MUL,   32'd3,   32'd4, 32'h0, 1, 0, 0, 0, 1);
    run_op("mulhu_off", OP_MULHU, 32'd3,   32'd4, 32'h0, 1, 0, 0, 0, 1);
    run_op("divu_off",  OP_DIVU,  32'd100, 32'd7, 32'h0, 1, 0, 0, 0, 1);
    run_op("remu_off",  OP_REMU,  32'd100, 32'd7, 32'h0, 1, 0, 0, 0, 1);
`endif
    run_op("pass", OP_PASS, 32'h92345678, 32'hDEAD, 32'h92345678, 0, 0, 0, 1, 1);

    // Abort a long operation with reset; it must never report done.
`ifdef ALU_MULDIV_EN
    drive(OP_DIVU, 32'd100, 32'd7);
`else
    drive(OP_SLL, 32'h1, 32'h1F);
`endif
    @(negedge clk); bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort.out", bus.alu_out, 0);
    chk("abort.zvcs", {bus.z, bus.v, bus.c, bus.s}, 4'b1000);
    chk("abort.busy_done", {bus.busy, bus.done}, 2'b00);
    repeat (2) begin
      @(negedge clk);
      chk("abort.hold_done", bus.done, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("abort.no_done", bus.done, 0);
    run_op("sub_eq", OP_SUB, 32'd5, 32'd5, 32'h0, 1, 0, 1, 0, 1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
